// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of instruction-memory and decode-side signals for the fetch controller.
// The controller uses the master view; the memory/decode environment uses slave.
interface imem_fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  halt,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output halt,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, reads the combinational
// instruction memory every cycle and buffers {pc, word} pairs in a small
// prefetch FIFO that feeds decode over a valid/ready handshake. Redirects
// from execute flush the FIFO and restart fetch at the new target.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    imem_fetch_ctrl_if.master  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic             fifo_valid;
    logic             pop;
    logic             push;

    assign fifo_valid = (count != '0);
    assign pop        = fifo_valid && bus.inst_ready;
    assign push       = !rst && !bus.redirect_valid && !bus.halt &&
                        ((count < DEPTH_CNT) || pop);

    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = fifo_valid;
    assign bus.inst_data  = fifo_valid ? data_mem[rd_ptr] : '0;
    assign bus.inst_pc    = fifo_valid ? pc_mem[rd_ptr]   : '0;

    // Capture the fetched word and its PC into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

    // Fetch PC, FIFO pointers and occupancy; reset beats redirect beats halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr   <= wr_ptr;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the fetch stream.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic clk;
    logic rst;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [64];
    logic [63:0] model_q [$];
    logic [31:0] model_pc;
    int          n_cmp;
    int          n_err;

    // Combinational instruction memory; only word bits [7:2] decode, so it aliases.
    assign bus.imem_rdata = mem[bus.imem_addr[7:2]];

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
        exp_valid = (model_q.size() > 0);
        exp_pc    = exp_valid ? model_q[0][63:32] : 32'h0;
        exp_data  = exp_valid ? model_q[0][31:0]  : 32'h0;
        check_eq("imem_addr",  bus.imem_addr,           model_pc);
        check_eq("inst_valid", 32'(bus.inst_valid),     32'(exp_valid));
        check_eq("inst_pc",    bus.inst_pc,             exp_pc);
        check_eq("inst_data",  bus.inst_data,           exp_data);
    endtask

    task automatic model_step(input bit r, input bit h, input bit rv,
                              input logic [31:0] rpc, input bit rdy);
        bit do_pop;
        bit room;
        if (r) begin
            model_q.delete();
            model_pc = RESET_PC;
        end else begin
            do_pop = (model_q.size() > 0) && rdy;
            room   = (model_q.size() < DEPTH) || do_pop;
            if (do_pop) void'(model_q.pop_front());
            if (rv) begin
                model_q.delete();
                model_pc = {rpc[31:2], 2'b00};
            end else if (!h && room) begin
                model_q.push_back({model_pc, mem[model_pc[7:2]]});
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit h, input bit rv,
                                 input logic [31:0] rpc, input bit rdy);
        checkOutput();
        rst                = r;
        bus.halt           = h;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = rdy;
        model_step(r, h, rv, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0093;
        mem[1] = 32'h0010_0113;
        model_q.delete();
        model_pc           = RESET_PC;
        rst                = 1'b1;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        @(negedge clk);

        // Reset state and startup fetch.
        applyStimulus(1, 0, 0, 32'h0, 1);
        check_eq("reset_valid", 32'(bus.inst_valid), 32'h0);
        check_eq("reset_addr",  bus.imem_addr,       RESET_PC);
        applyStimulus(0, 0, 0, 32'h0, 1);
        check_eq("start_pc0",   bus.inst_pc,   32'h0);
        check_eq("start_data0", bus.inst_data, 32'h0000_0093);
        applyStimulus(0, 0, 0, 32'h0, 1);
        check_eq("start_pc1",   bus.inst_pc,   32'h4);
        check_eq("start_data1", bus.inst_data, 32'h0010_0113);

        // Backpressure: FIFO fills and fetch stalls at 8.
        applyStimulus(1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 32'h0, 0);
        check_eq("bp_addr", bus.imem_addr, 32'h8);
        check_eq("bp_head", bus.inst_pc,   32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        check_eq("bp_drain1", bus.inst_pc, 32'h4);
        applyStimulus(0, 0, 0, 32'h0, 1);
        check_eq("bp_drain2", bus.inst_pc, 32'h8);

        // Redirect with a simultaneous pop.
        applyStimulus(0, 0, 1, 32'h10, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        check_eq("rd_head", bus.inst_pc, 32'h10);
        applyStimulus(0, 0, 1, 32'h0000_0103, 1);
        check_eq("rd_addr",  bus.imem_addr,       32'h100);
        check_eq("rd_flush", 32'(bus.inst_valid), 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        check_eq("rd_target", bus.inst_pc, 32'h100);

        // Halt with two entries buffered at fetch PC 0x20.
        applyStimulus(0, 0, 1, 32'h18, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 32'h0, 1);
        applyStimulus(0, 1, 0, 32'h0, 1);
        check_eq("halt_addr",  bus.imem_addr,       32'h20);
        check_eq("halt_empty", 32'(bus.inst_valid), 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1);
        check_eq("halt_resume", bus.inst_pc, 32'h20);

        // Address wrap-around.
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 1);
        applyStimulus(0, 0, 0, 32'h0, 1);
        check_eq("wrap_pc0", bus.inst_pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 32'h0, 1);
        check_eq("wrap_pc1", bus.inst_pc, 32'h0);

        // Reset mid-operation overrides a concurrent redirect.
        applyStimulus(0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        applyStimulus(1, 1, 1, 32'h200, 1);
        check_eq("mrst_valid", 32'(bus.inst_valid), 32'h0);
        check_eq("mrst_addr",  bus.imem_addr,       RESET_PC);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 9) == 0),
                          $urandom,
                          ($urandom_range(0, 9) < 7));
        end
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
